sum_job_arbiter: RTL and testbench

//  Shares one go_l/inA/done/outResult summing accumulator between two requesters.

---
 rtl/sum_job_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sum_job_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_job_arbiter.sv
// Two-requester front end for a single go_l/inA/done summing accumulator.
// A job is collected into a small buffer, streamed out with a zero terminator, and its sum is returned.
module sum_job_arbiter #(
   parameter int WIDTH          = 16,
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req_valid,
   input  logic [2*WIDTH-1:0] req_data,
   input  logic [1:0]         req_last,
   output logic [1:0]         req_ready,
   output logic [WIDTH-1:0]   inA,
   output logic               go_l,
   input  logic               done,
   input  logic [WIDTH-1:0]   outResult,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [WIDTH-1:0]   rsp_result,
   output logic               rsp_overflow,
   output logic               rsp_timeout,
   output logic               busy
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, WAIT, RESPOND} state_t;

   state_t           state;
   logic             grant;
   logic             last_srv;
   logic             ovf;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    idx;
   logic [TW-1:0]    tcnt;
   logic [WIDTH-1:0] buf_q [2**IW];

   logic             pick;
   logic [WIDTH-1:0] g_data;
   logic             g_last, g_acc, g_store, g_drop;
   logic [CW-1:0]    cnt_nxt, idx_nxt;
   logic [WIDTH-1:0] buf0_nxt;

   always_comb begin
      // tie goes to whoever was not served last
      pick     = (req_valid == 2'b11) ? ~last_srv : req_valid[1];
      g_data   = grant ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
      g_last   = req_last[grant];
      g_acc    = req_valid[grant] & req_ready[grant];
      g_store  = g_acc && (g_data != '0) && (cnt < CW'(DEPTH));
      g_drop   = g_acc && (g_data != '0) && (cnt >= CW'(DEPTH));
      cnt_nxt  = g_store ? cnt + CW'(1) : cnt;
      idx_nxt  = idx + CW'(1);
      // first operand may be landing in the buffer on the same edge that starts ISSUE
      buf0_nxt = (g_store && cnt == '0) ? g_data : buf_q[0];
   end

   always_ff @(posedge clk) begin
      if (state == COLLECT && g_store) buf_q[cnt[IW-1:0]] <= g_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         go_l         <= 1'b1;
         inA          <= '0;
         req_ready    <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_result   <= '0;
         rsp_overflow <= 1'b0;
         rsp_timeout  <= 1'b0;
         busy         <= 1'b0;
         grant        <= 1'b0;
         last_srv     <= 1'b1;
         ovf          <= 1'b0;
         cnt          <= '0;
         idx          <= '0;
         tcnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant     <= pick;
                  req_ready <= pick ? 2'b10 : 2'b01;
                  cnt       <= '0;
                  ovf       <= 1'b0;
                  busy      <= 1'b1;
                  state     <= COLLECT;
               end
            end
            COLLECT: begin
               if (g_acc) begin
                  cnt <= cnt_nxt;
                  if (g_drop) ovf <= 1'b1;
                  if (g_last) begin
                     req_ready <= '0;
                     if (cnt_nxt != '0) begin
                        inA   <= buf0_nxt;
                        go_l  <= 1'b0;
                        idx   <= '0;
                        state <= ISSUE;
                     end else begin
                        rsp_valid    <= 1'b1;
                        rsp_id       <= grant;
                        rsp_result   <= '0;
                        rsp_overflow <= ovf | g_drop;
                        rsp_timeout  <= 1'b0;
                        state        <= RESPOND;
                     end
                  end
               end
            end
            ISSUE: begin
               go_l <= 1'b1;
               // idx is the word currently on inA; idx == cnt is the terminator cycle
               if (idx == cnt) begin
                  inA   <= '0;
                  tcnt  <= '0;
                  state <= WAIT;
               end else begin
                  idx <= idx_nxt;
                  inA <= (idx_nxt < cnt) ? buf_q[idx_nxt[IW-1:0]] : '0;
               end
            end
            WAIT: begin
               if (done) begin
                  rsp_valid    <= 1'b1;
                  rsp_id       <= grant;
                  rsp_result   <= outResult;
                  rsp_overflow <= ovf;
                  rsp_timeout  <= 1'b0;
                  state        <= RESPOND;
               end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_valid    <= 1'b1;
                  rsp_id       <= grant;
                  rsp_result   <= '0;
                  rsp_overflow <= ovf;
                  rsp_timeout  <= 1'b1;
                  state        <= RESPOND;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            RESPOND: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  last_srv  <= grant;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sum_job_arbiter.sv
// Randomized bench for sum_job_arbiter: job-level reference (round-robin order, truncated
// nonzero operand lists, sums) plus an accumulator model that drives done/outResult.
module tb_sum_job_arbiter;
   localparam int W = 16;
   localparam int D = 4;
   localparam int T = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic [1:0]     req_valid, req_last, req_ready;
   logic [2*W-1:0] req_data;
   logic [W-1:0]   inA, outResult, rsp_result;
   logic           go_l, done, rsp_valid, rsp_ready, rsp_id, rsp_overflow, rsp_timeout, busy;

   sum_job_arbiter #(.WIDTH(W), .DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .inA(inA), .go_l(go_l), .done(done), .outResult(outResult),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout), .busy(busy));

   always #5 clk = ~clk;

   typedef struct packed {
      logic              id;
      logic [W-1:0]      res;
      logic              ovf;
      logic              to;
      logic [3:0]        n;
      logic [D-1:0][W-1:0] w;
   } exp_t;

   int checks = 0, errors = 0;
   exp_t expq[$];
   int   rid_log[$];
   logic [W-1:0] jw [2][16];
   int   jn [2];
   bit   dead = 0, mon_en = 0;
   int   last_srv = 1, nresp = 0;

   // monitor state
   bit streaming = 0, pending = 0, stream_seen = 0, rsp_seen = 0;
   int sn = 0, ls_n = 0, dly = 0, lat = 0, cyc_ctr = 0, term_cyc = 0;
   logic [W-1:0] s_w [16];
   logic [W-1:0] ls [16];
   logic [W-1:0] acc_sum;
   exp_t h;
   logic lr_id, lr_ovf, lr_to;
   logic [W-1:0] lr_res;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t build_exp(input int id);
      exp_t e;
      int nz = 0;
      logic [W-1:0] s = '0;
      e = '0;
      e.id = id[0];
      for (int k = 0; k < jn[id]; k++) begin
         if (jw[id][k] != '0) begin
            if (nz < D) begin
               e.w[nz] = jw[id][k];
               s = s + jw[id][k];
            end
            nz++;
         end
      end
      e.n   = 4'((nz < D) ? nz : D);
      e.ovf = (nz > D);
      if (e.n == 0)  e.res = '0;
      else if (dead) begin e.res = '0; e.to = 1'b1; end
      else           e.res = s;
      return e;
   endfunction

   // accumulator model, stream/response checker
   initial begin
      done = 1'b0;
      outResult = '0;
      forever begin
         @(negedge clk);
         if (reset || !mon_en) begin
            streaming = 0; pending = 0; done = 1'b0; stream_seen = 0; rsp_seen = 0;
         end else begin
            cyc_ctr++;
            if (pending) begin
               if (dly == 0) begin done = 1'b1; outResult = acc_sum; pending = 0; end
               else begin dly--; done = 1'b0; outResult = W'($urandom); end
            end else begin
               done = !dead && ($urandom_range(0, 7) == 0);
               outResult = W'($urandom);
            end
            if (req_ready != 2'b00)
               chk("req_ready_owner",
                   (expq.size() > 0 && req_ready == (2'b01 << expq[0].id)) ? 1 : 0, 1);
            if (expq.size() == 0) chk("busy_idle", busy, 0);
            if (!streaming) begin
               if (!go_l) begin
                  streaming = 1; sn = 1; s_w[0] = inA; acc_sum = inA;
               end else chk("inA_idle", inA, 0);
            end else begin
               chk("go_l_single", go_l, 1);
               if (inA == '0) begin
                  streaming = 0;
                  h = (expq.size() > 0) ? expq[0] : '0;
                  chk("stream_len", sn, (expq.size() > 0) ? h.n : -1);
                  for (int j = 0; j < sn && j < D; j++) chk("stream_word", s_w[j], h.w[j]);
                  for (int j = 0; j < 16; j++) ls[j] = s_w[j];
                  ls_n = sn; stream_seen = 1; term_cyc = cyc_ctr;
                  lat = $urandom_range(0, 5); dly = lat; pending = !dead;
               end else begin
                  if (sn < 16) s_w[sn] = inA;
                  sn++;
                  acc_sum = acc_sum + inA;
               end
            end
            if (rsp_valid) begin
               if (expq.size() == 0) chk("rsp_unexpected", 1, 0);
               else begin
                  h = expq[0];
                  if (!rsp_seen) begin
                     rsp_seen = 1;
                     chk("stream_seen", stream_seen, (h.n != 0) ? 1 : 0);
                     if (h.n != 0) chk("rsp_latency", cyc_ctr - term_cyc, h.to ? T + 1 : lat + 2);
                  end
                  chk("rsp_id", rsp_id, h.id);
                  chk("rsp_result", rsp_result, h.res);
                  chk("rsp_overflow", rsp_overflow, h.ovf);
                  chk("rsp_timeout", rsp_timeout, h.to);
                  chk("busy_rsp", busy, 1);
                  if (rsp_ready) begin
                     void'(expq.pop_front());
                     rid_log.push_back(int'(rsp_id));
                     lr_id = rsp_id; lr_res = rsp_result; lr_ovf = rsp_overflow; lr_to = rsp_timeout;
                     nresp++; rsp_seen = 0; stream_seen = 0;
                  end
               end
            end
         end
      end
   end

   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic do_reset();
      mon_en = 0;
      reset = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      last_srv = 1;
      expq.delete();
      mon_en = 1;
   endtask

   task automatic run_round(input bit e0, input bit e1, input bit dd);
      int k [2];
      bit en [2];
      bit acc [2];
      int target, first, cyc;
      en[0] = e0; en[1] = e1; k[0] = 0; k[1] = 0;
      dead = dd;
      if (e0 && e1) begin
         first = 1 - last_srv;
         expq.push_back(build_exp(first));
         expq.push_back(build_exp(1 - first));
         last_srv = 1 - first;
         target = nresp + 2;
      end else begin
         first = e1 ? 1 : 0;
         expq.push_back(build_exp(first));
         last_srv = first;
         target = nresp + 1;
      end
      @(posedge clk);
      #1;
      cyc = 0;
      while (nresp < target && cyc < 3000) begin
         for (int i = 0; i < 2; i++) begin
            bit active;
            active = en[i] && (k[i] < jn[i]);
            req_valid[i] = active && (k[i] == 0 || $urandom_range(0, 3) != 0);
            req_data[i*W +: W] = active ? jw[i][k[i]] : W'($urandom);
            req_last[i] = active ? (k[i] == jn[i] - 1) : ($urandom_range(0, 1) == 1);
         end
         @(negedge clk);
         for (int i = 0; i < 2; i++) acc[i] = req_valid[i] && req_ready[i];
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) if (acc[i]) k[i]++;
         cyc++;
      end
      req_valid = '0;
      if (cyc >= 3000) chk("round_timeout", nresp, target);
      dead = 0;
   endtask

   task automatic set_job(input int id, input int n, input int w0, input int w1, input int w2,
                          input int w3, input int w4, input int w5);
      int v [6];
      v = '{w0, w1, w2, w3, w4, w5};
      jn[id] = n;
      for (int k = 0; k < 6; k++) jw[id][k] = W'(v[k]);
   endtask

   initial begin
      int n0, guard;
      bit seen, acc0;
      logic [W-1:0] w6 [3];
      reset = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_go_l", go_l, 1);
      chk("rst_inA", inA, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_flags", {rsp_overflow, rsp_timeout}, 0);
      chk("rst_busy", busy, 0);
      do_reset();

      // tie right after reset: requester 0 first
      set_job(0, 1, 3, 0, 0, 0, 0, 0);
      set_job(1, 1, 4, 0, 0, 0, 0, 0);
      n0 = rid_log.size();
      run_round(1, 1, 0);
      chk("tie1_first", rid_log[n0], 0);
      chk("tie1_second", rid_log[n0+1], 1);

      set_job(0, 3, 55, 22, 1, 0, 0, 0);
      run_round(1, 0, 0);
      chk("t1_len", ls_n, 3);
      chk("t1_w0", ls[0], 55);
      chk("t1_w1", ls[1], 22);
      chk("t1_w2", ls[2], 1);
      chk("t1_res", lr_res, 78);
      chk("t1_id", lr_id, 0);
      chk("t1_flags", {lr_ovf, lr_to}, 0);

      // requester 0 was served last, so the next tie favours requester 1
      set_job(0, 1, 8, 0, 0, 0, 0, 0);
      set_job(1, 1, 9, 0, 0, 0, 0, 0);
      n0 = rid_log.size();
      run_round(1, 1, 0);
      chk("tie2_first", rid_log[n0], 1);
      chk("tie2_second", rid_log[n0+1], 0);

      set_job(1, 3, 5, 0, 7, 0, 0, 0);
      run_round(0, 1, 0);
      chk("t3_len", ls_n, 2);
      chk("t3_w0", ls[0], 5);
      chk("t3_w1", ls[1], 7);
      chk("t3_res", lr_res, 12);
      set_job(1, 1, 0, 0, 0, 0, 0, 0);
      run_round(0, 1, 0);
      chk("t3_empty_res", lr_res, 0);
      chk("t3_empty_id", lr_id, 1);

      set_job(0, 6, 1, 1, 1, 1, 1, 1);
      run_round(1, 0, 0);
      chk("t4_len", ls_n, 4);
      chk("t4_res", lr_res, 4);
      chk("t4_ovf", lr_ovf, 1);

      set_job(0, 1, 9, 0, 0, 0, 0, 0);
      run_round(1, 0, 1);
      chk("t5_to", lr_to, 1);
      chk("t5_res", lr_res, 0);

      for (int r = 0; r < 40; r++) begin
         bit e0, e1;
         int pat;
         pat = $urandom_range(1, 3);
         e0 = pat[0]; e1 = pat[1];
         for (int i = 0; i < 2; i++) begin
            jn[i] = $urandom_range(1, 7);
            for (int k = 0; k < 16; k++)
               jw[i][k] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 65535));
         end
         run_round(e0, e1, $urandom_range(0, 7) == 0);
      end

      // reset in the middle of ISSUE discards the job
      mon_en = 0;
      w6 = '{W'(5), W'(6), W'(7)};
      req_valid = 2'b01;
      for (int k = 0; k < 3; k++) begin
         req_data[W-1:0] = w6[k];
         req_last = (k == 2) ? 2'b01 : 2'b00;
         guard = 0;
         do begin
            @(negedge clk);
            acc0 = req_ready[0];
            @(posedge clk);
            #1;
            guard++;
         end while (!acc0 && guard < 50);
         if (!acc0) chk("t6_accept", 0, 1);
      end
      req_valid = '0;
      guard = 0;
      seen = 0;
      while (!seen && guard < 50) begin
         @(negedge clk);
         seen = !go_l;
         guard++;
      end
      chk("t6_go_seen", seen, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_go_l", go_l, 1);
      chk("t6_inA", inA, 0);
      chk("t6_busy", busy, 0);
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_req_ready", req_ready, 0);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (rsp_valid || busy || !go_l) seen = 1;
      end
      chk("t6_no_response", seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      errors++;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
